// File: rtl/cke_debounce.sv
// Per-lane debouncer paced by cke rising edges, with rise/fall pulses.
// Optional auto-repeat on held-high lanes: define CKE_DEBOUNCE_REPEAT_EN.
module cke_debounce #(
    parameter int WIDTH = 1,
    parameter int N     = 4,
    parameter int HOLD  = 32,
    parameter int RPT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             cke,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             tick
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CLAST = CW'(N - 1);

    logic                      cke_q;
    logic                      edge_e;
    logic                      tick_q, tick_d;
    logic [WIDTH-1:0]          s1_q, sync_q;
    logic [WIDTH-1:0]          dout_q, dout_d;
    logic [WIDTH-1:0]          rise_q, rise_d;
    logic [WIDTH-1:0]          fall_q, fall_d;
    logic [WIDTH-1:0]          flip;
    logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;

`ifdef CKE_DEBOUNCE_REPEAT_EN
    localparam int RW = $clog2((HOLD > RPT ? HOLD : RPT) + 1);
    localparam logic [RW-1:0] RHOLD = RW'(HOLD);
    localparam logic [RW-1:0] RRPT  = RW'(RPT);

    logic [WIDTH-1:0][RW-1:0]  rcnt_q, rcnt_d;
    logic [WIDTH-1:0]          armed_q, armed_d;
    logic [WIDTH-1:0][RW-1:0]  rnext;
`endif

    always_comb begin
        edge_e = cke & ~cke_q & ena;
        tick_d = edge_e;
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        flip   = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (edge_e) begin
                if (sync_q[i] == dout_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CLAST) begin
                    cnt_d[i]  = '0;
                    flip[i]   = 1'b1;
                    dout_d[i] = sync_q[i];
                    rise_d[i] = sync_q[i];
                    fall_d[i] = ~sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
`ifdef CKE_DEBOUNCE_REPEAT_EN
        rcnt_d  = rcnt_q;
        armed_d = armed_q;
        for (int i = 0; i < WIDTH; i++) begin
            rnext[i] = rcnt_q[i] + 1'b1;
            // A flip in either direction restarts the hold interval.
            if (!dout_q[i] || flip[i]) begin
                rcnt_d[i]  = '0;
                armed_d[i] = 1'b0;
            end else if (edge_e) begin
                if (rnext[i] == (armed_q[i] ? RRPT : RHOLD)) begin
                    rise_d[i]  = 1'b1;
                    rcnt_d[i]  = '0;
                    armed_d[i] = 1'b1;
                end else begin
                    rcnt_d[i] = rnext[i];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cke_q  <= 1'b1;
            tick_q <= 1'b0;
            s1_q   <= '0;
            sync_q <= '0;
            dout_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '0;
        end else begin
            cke_q  <= cke;
            tick_q <= tick_d;
            s1_q   <= din;
            sync_q <= s1_q;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef CKE_DEBOUNCE_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q  <= '0;
            armed_q <= '0;
        end else begin
            rcnt_q  <= rcnt_d;
            armed_q <= armed_d;
        end
    end
`endif

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_cke_debounce.sv
// Directed bench for cke_debounce: reset, press/release, bounce,
// enable freeze, multi-lane and (when enabled) auto-repeat.
module tb_cke_debounce;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       cke;
    logic [2:0] din;
    logic [2:0] dout, rise, fall;
    logic       tick;

    int n_vec = 0;
    int n_err = 0;
    int n_rise, n_fall, n_tick;
    logic [2:0] or_rise;
    logic [2:0] e_dout, e_rise, e_fall;
    logic       e_tick;
    logic       er_rise, er_fall;

    cke_debounce #(.WIDTH(3), .N(4), .HOLD(4000), .RPT(4000)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .cke(cke), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .tick(tick)
    );

`ifdef CKE_DEBOUNCE_REPEAT_EN
    logic r_dout, r_rise, r_fall, r_tick;
    cke_debounce #(.WIDTH(1), .N(4), .HOLD(8), .RPT(4)) u_rpt (
        .clk(clk), .rst(rst), .ena(ena), .cke(cke), .din(din[0]),
        .dout(r_dout), .rise(r_rise), .fall(r_fall), .tick(r_tick)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_rise  = 0;
        n_fall  = 0;
        n_tick  = 0;
        or_rise = '0;
    endtask

    task automatic acc();
        if (rise != 0) n_rise++;
        if (fall != 0) n_fall++;
        if (tick) n_tick++;
        or_rise |= rise;
    endtask

    // One cke period: 5 clk low, then 5 clk high; edge results latched.
    task automatic period();
        cke = 1'b0;
        repeat (5) begin @(negedge clk); acc(); end
        cke = 1'b1;
        @(negedge clk);
        acc();
        e_tick = tick;
        e_dout = dout;
        e_rise = rise;
        e_fall = fall;
`ifdef CKE_DEBOUNCE_REPEAT_EN
        er_rise = r_rise;
        er_fall = r_fall;
`endif
        repeat (4) begin @(negedge clk); acc(); end
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        cke = 1'b0;
        din = '0;
        er_rise = 1'b0;
        er_fall = 1'b0;
        clr();
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_pulses", {rise, fall, tick}, 0);
        rst = 1'b0;

        // Reset in the middle of a debounce count
        din = 3'b001;
        period();
        period();
        check("mid_dout", dout, 0);
        cke = 1'b0;
        repeat (5) @(negedge clk);
        cke = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_tick", tick, 1);
        rst = 1'b1;
        #1;
        check("async_rst_tick", tick, 0);
        check("async_rst_dout", dout, 0);
        @(negedge clk);
        rst = 1'b0;
        clr();
        repeat (4) begin @(negedge clk); acc(); end
        check("no_spurious_tick", n_tick, 0);
        clr();
        repeat (3) period();
        check("post_rst_3edges", dout, 0);
        period();
        check("press_dout", e_dout, 3'b001);
        check("press_rise", e_rise, 3'b001);
        check("press_tick", e_tick, 1);
        check("press_nrise", n_rise, 1);

        // Clean release
        din = 3'b000;
        clr();
        repeat (3) period();
        check("rel_3edges", dout, 3'b001);
        period();
        check("rel_dout", e_dout, 0);
        check("rel_fall", e_fall, 3'b001);
        check("rel_nfall", n_fall, 1);
        check("rel_nrise", n_rise, 0);

        // Bounce: 1,1,1,0 then clean high
        for (int k = 0; k < 4; k++) begin
            din = (k == 3) ? 3'b000 : 3'b001;
            period();
        end
        check("bounce_dout", dout, 0);
        din = 3'b001;
        repeat (3) period();
        check("bounce_no_credit", dout, 0);
        period();
        check("bounce_clean_dout", dout, 3'b001);
        din = 3'b000;
        repeat (4) period();
        check("bounce_rel_dout", dout, 0);

        // Enable freeze
        din = 3'b001;
        period();
        period();
        ena = 1'b0;
        clr();
        repeat (3) period();
        check("frz_ntick", n_tick, 0);
        check("frz_dout", dout, 0);
        cke = 1'b0;
        repeat (5) @(negedge clk);
        cke = 1'b1;
        @(negedge clk);
        ena = 1'b1;
        clr();
        repeat (4) begin @(negedge clk); acc(); end
        check("ena_hi_no_edge", n_tick, 0);
        period();
        check("ena_edge1_tick", e_tick, 1);
        check("ena_edge1_dout", e_dout, 0);
        period();
        check("ena_edge2_dout", e_dout, 3'b001);
        check("ena_edge2_rise", e_rise, 3'b001);
        din = 3'b000;
        repeat (4) period();
        check("ena_rel_dout", dout, 0);

        // Multi-lane simultaneous step
        din = 3'b101;
        clr();
        repeat (3) period();
        check("ml_3edges", dout, 0);
        period();
        check("ml_dout", e_dout, 3'b101);
        check("ml_rise", e_rise, 3'b101);
        check("ml_or_rise", or_rise, 3'b101);
        check("ml_nrise", n_rise, 1);

`ifdef CKE_DEBOUNCE_REPEAT_EN
        din = 3'b000;
        repeat (4) period();
        check("rpt_idle", r_dout, 0);
        din = 3'b001;
        for (int p = 1; p <= 20; p++) begin
            period();
            check($sformatf("rpt_p%0d", p), er_rise,
                  (p == 4 || p == 12 || p == 16 || p == 20) ? 1 : 0);
        end
        din = 3'b000;
        for (int p = 21; p <= 24; p++) begin
            period();
            check($sformatf("rpt_rel_p%0d", p), er_rise, 0);
        end
        check("rpt_fall", er_fall, 1);
        check("rpt_dout", r_dout, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cke_debounce.md
Name: cke_debounce

Overview:
- Per-lane input debouncer clocked by `clk` and paced by the half-duty `cke` level from the clock splitter.
- Converts each `cke` rising edge into a one-cycle sample tick.
- Filters `WIDTH` asynchronous inputs (buttons, switches) and presents stable levels plus one-cycle rise/fall pulses to downstream UTILS/IO logic.

Parameters:
- WIDTH, 1: number of independent input lanes; legal range ≥1.
- N, 4: consecutive differing sample ticks required before a lane's `dout` flips; legal range ≥1.
- HOLD, 32: ticks `dout` must stay high before the first auto-repeat pulse (optional feature only).
- RPT, 8: ticks between subsequent auto-repeat pulses (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ena  in  1  global enable; low freezes all lane state
- cke  in  1  half-duty enable level from the clock splitter
- din  in  WIDTH  raw asynchronous lane inputs
- dout  out  WIDTH  debounced lane levels
- rise  out  WIDTH  one-cycle pulse: lane `dout` went 0→1, or an auto-repeat fired
- fall  out  WIDTH  one-cycle pulse: lane `dout` went 1→0
- tick  out  1  one-cycle pulse marking each accepted sample edge

Behaviour:
- Reset (async, active-high) clears all state immediately:
  - `dout`, `rise`, `fall`, `tick` = 0
  - all lane counters = 0, synchronizer flops = 0
  - `cke_q` = 1, so a `cke` already high at reset release produces no spurious edge
- Synchronizer: two flops per lane on `din` → `sync`. A `din` change becomes visible in `sync` 2 clk later.
- Edge detect: `cke_q` registers `cke` every cycle regardless of `ena`.
  - Internal edge e = `cke` & ~`cke_q` & `ena`.
  - `cke` held high produces exactly one edge.
  - Raising `ena` while `cke` is already high produces no edge until the next 0→1 transition of `cke`.
- `tick` is registered e: high for exactly one cycle, the same cycle in which any resulting `dout`/`rise`/`fall` updates become visible.
- Lane counter: `cnt`, width $clog2(N+1). Evaluated only on a cycle where e=1:
  - `sync` == `dout` → `cnt` = 0.
  - `sync` != `dout` and `cnt` == N-1 → `dout` <= `sync`; `cnt` = 0; pulse `rise` (new level 1) or `fall` (new level 0) for one cycle.
  - `sync` != `dout`, otherwise → `cnt` + 1.
- With N=1, `dout` flips on the first edge that sees a differing `sync`.
- Any non-edge cycle: `cnt` and `dout` hold; `rise`/`fall`/`tick` = 0.
- Bounce: any edge on which `sync` returns to `dout` restarts the count from 0. There is no partial credit.
- `ena` low: no edges are accepted and all counters and `dout` hold. Pulses already in flight still deassert the following cycle.
- Lanes are fully independent. Simultaneous flips on several lanes all pulse on the same cycle.
- Latency bound: a clean `din` step is reflected in `dout` on the Nth accepted edge after `sync` changes.

Optional Feature:
- Macro: CKE_DEBOUNCE_REPEAT_EN
- Defined:
  - Each lane has a repeat counter, cleared whenever `dout` is 0 or a flip occurs.
  - While `dout` = 1, the counter increments on each accepted edge.
  - On the HOLD-th edge after the rising flip, `rise` pulses and the counter reloads.
  - Thereafter `rise` pulses every RPT edges while `dout` stays 1.
  - A falling flip cancels repeat at once; no repeat pulse accompanies a `fall`.
  - `ena` low freezes the repeat counter.
- Undefined: the repeat logic is absent, HOLD/RPT are ignored, and `rise` pulses only on 0→1 flips.

Test Plan:
- Reset mid-debounce: WIDTH=1, N=4, `cke` period 10 clk (5 high). Hold `din`=1 for 2 edges, then pulse `rst` for 1 clk → `dout`/`rise`/`fall`/`tick` = 0 asynchronously. After release with `din` still 1, `dout` rises only on the 4th subsequent edge.
- Clean press/release: `din` 0→1 held → `dout`=1 with `rise`=1 and `tick`=1 on the same single cycle, at the 4th edge after `sync`=1. `din` 1→0 held → `fall` single pulse at the 4th edge; `rise` stays 0.
- Bounce rejection: `din` alternates 1,1,1,0 across four edges → `dout` stays 0 and `cnt` returns to 0. Then 4 clean high edges → `dout`=1.
- Enable freeze: `ena` dropped after 2 counted edges for 30 clk → no `tick`, `dout` unchanged. `ena` raised while `cke`=1 → no edge that cycle; `dout` flips on the 2nd following `cke` rise.
- Multi-lane: WIDTH=3, `din`=3'b101 stepped simultaneously → `dout`=3'b101 and `rise`=3'b101 on the same cycle; lane 1 stays silent.
- Repeat (macro defined, HOLD=8, RPT=4): `din` held 1 → `rise` pulses at the flip edge, then 8 edges later, then every 4 edges. `din` released → `fall` pulse; no further `rise`.
